// File: rtl/mc14500b_seq_if.sv
// ----------------------------------------------------------------------------
// mc14500b_seq_if
// Bus between the MC14500B program sequencer and the ICU, program ROM and
// I/O pins. master = sequencer side, slave = ICU/ROM/pin side.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mc14500b_seq_if #(
  parameter int ADDR_W = 8,
  parameter int IO_W   = 3
);
  logic [ADDR_W-1:0]    PC;
  logic [ADDR_W+3:0]    ROM_DATA;
  logic [3:0]           INSTR;
  logic                 JMP;
  logic                 RTN;
  logic                 FLG0;
  logic                 FLGF;
  logic                 WRITE;
  logic                 DATA_FROM_ICU;
  logic                 DATA_TO_ICU;
  logic [(1<<IO_W)-1:0] IN_PORT;
  logic [(1<<IO_W)-1:0] OUT_PORT;
  logic                 HALT;
  logic                 STK_ERR;

  modport master (
    output PC, INSTR, DATA_TO_ICU, OUT_PORT, HALT, STK_ERR,
    input  ROM_DATA, JMP, RTN, FLG0, FLGF, WRITE, DATA_FROM_ICU, IN_PORT
  );

  modport slave (
    input  PC, INSTR, DATA_TO_ICU, OUT_PORT, HALT, STK_ERR,
    output ROM_DATA, JMP, RTN, FLG0, FLGF, WRITE, DATA_FROM_ICU, IN_PORT
  );
endinterface

`default_nettype wire

// File: rtl/mc14500b_seq.sv
// ----------------------------------------------------------------------------
// mc14500b_seq
// Program sequencer and I/O map for the MC14500B ICU: program counter,
// jump/call/return/halt handling, addressed input mux and output latches.
// Optional call stack: define MC14500B_CALL_STACK_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mc14500b_seq #(
  parameter int ADDR_W = 8,
  parameter int IO_W   = 3
`ifdef MC14500B_CALL_STACK_EN
  , parameter int STACK_DEPTH = 4
`endif
) (
  input  logic           X2,
  input  logic           RST,
  mc14500b_seq_if.master bus
);

  localparam int NIO = 1 << IO_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] op_q, op_d;
  logic [NIO-1:0]    out_q, out_d;
  logic              halt_q, halt_d;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] pc_inc;

  assign operand = bus.ROM_DATA[ADDR_W-1:0];
  assign pc_inc  = pc_q + ADDR_W'(1);

`ifdef MC14500B_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              stk_err_q, stk_err_d;
  logic [IDX_W-1:0]  push_idx, pop_idx;

  // sp counts filled entries; the top entry sits one below the push slot
  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = push_idx - IDX_W'(1);
`endif

  // Next-state: latch write, then PC priority halt > FLGF > RTN > FLG0 > JMP > +1
  always_comb begin
    op_d   = operand;
    out_d  = out_q;
    pc_d   = pc_q;
    halt_d = halt_q;
`ifdef MC14500B_CALL_STACK_EN
    stack_d   = stack_q;
    sp_d      = sp_q;
    stk_err_d = stk_err_q;
`endif

    // Store data belongs to the instruction executed on the previous edge
    if (bus.WRITE) begin
      out_d[op_q[IO_W-1:0]] = bus.DATA_FROM_ICU;
    end

    if (halt_q) begin
      pc_d = pc_q;
    end else if (bus.FLGF) begin
      halt_d = 1'b1;
    end else if (bus.RTN) begin
`ifdef MC14500B_CALL_STACK_EN
      if (sp_q == '0) begin
        pc_d      = '0;
        stk_err_d = 1'b1;
      end else begin
        pc_d = stack_q[pop_idx];
        sp_d = sp_q - SP_W'(1);
      end
`else
      pc_d = '0;
`endif
    end else if (bus.FLG0) begin
`ifdef MC14500B_CALL_STACK_EN
      // Return lands after the delay slot, which is the current PC
      pc_d = op_q;
      if (sp_q == SP_W'(STACK_DEPTH)) begin
        stk_err_d = 1'b1;
      end else begin
        stack_d[push_idx] = pc_inc;
        sp_d              = sp_q + SP_W'(1);
      end
`else
      pc_d = pc_inc;
`endif
    end else if (bus.JMP) begin
      pc_d = op_q;
    end else begin
      pc_d = pc_inc;
    end
  end

  // State registers, asynchronously cleared
  always_ff @(posedge X2 or posedge RST) begin
    if (RST) begin
      pc_q   <= '0;
      op_q   <= '0;
      out_q  <= '0;
      halt_q <= 1'b0;
`ifdef MC14500B_CALL_STACK_EN
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
      sp_q      <= '0;
      stk_err_q <= 1'b0;
`endif
    end else begin
      pc_q   <= pc_d;
      op_q   <= op_d;
      out_q  <= out_d;
      halt_q <= halt_d;
`ifdef MC14500B_CALL_STACK_EN
      stack_q   <= stack_d;
      sp_q      <= sp_d;
      stk_err_q <= stk_err_d;
`endif
    end
  end

  assign bus.PC       = pc_q;
  assign bus.INSTR    = halt_q ? 4'hF : bus.ROM_DATA[ADDR_W+3:ADDR_W];
  assign bus.OUT_PORT = out_q;
  assign bus.HALT     = halt_q;
  // Operand bit IO_W selects latch readback instead of the input pins
  assign bus.DATA_TO_ICU = operand[IO_W] ? out_q[operand[IO_W-1:0]]
                                         : bus.IN_PORT[operand[IO_W-1:0]];
`ifdef MC14500B_CALL_STACK_EN
  assign bus.STK_ERR = stk_err_q;
`else
  assign bus.STK_ERR = 1'b0;
`endif

endmodule

`default_nettype wire
